// File: rtl/main_mem_arbiter_pkg.sv
// main_mem_arb_pkg: shared types, widths and the address-decode helper for the MainMemory arbiter.
package main_mem_arb_pkg;

    localparam int DW = 256;
    localparam int AW = 16;
    localparam logic [3:0] MAIN_MEM_SEL = 4'd0;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} arb_state_t;

    // MainMemory owns module select 0; only the first depth words exist.
    function automatic logic addr_valid(input logic [AW-1:0] a, input int depth);
        return (a[15:12] == MAIN_MEM_SEL) && (int'(a[11:0]) < depth);
    endfunction

endpackage

// File: rtl/main_mem_arbiter_if.sv
// main_mem_arbiter_if: requester handshake plus MainMemory port bundle; slave = arbiter side.
interface main_mem_arbiter_if #(
    parameter int NREQ = 3,
    parameter int DW   = main_mem_arb_pkg::DW,
    parameter int AW   = main_mem_arb_pkg::AW
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    wr;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               err;
    logic [DW-1:0]      rdata;
    logic               busy;
    logic [AW-1:0]      address;
    logic               nRead;
    logic               nWrite;
    logic [DW-1:0]      ExeDataOut;
    logic [DW-1:0]      MemDataOut;

    modport slave (
        input  req, wr, req_addr, req_wdata, MemDataOut,
        output gnt, done, err, rdata, busy, address, nRead, nWrite, ExeDataOut
    );

    modport master (
        output req, wr, req_addr, req_wdata, MemDataOut,
        input  gnt, done, err, rdata, busy, address, nRead, nWrite, ExeDataOut
    );

endinterface

// File: rtl/main_mem_arbiter_picker.sv
// main_mem_rr_picker: combinational round-robin winner search starting after ptr; MAIN_MEM_ARB_PRIO_EN gives requester 0 strict priority.
module main_mem_rr_picker #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0] cand;
    int j;

`ifdef MAIN_MEM_ARB_PRIO_EN
    assign cand = req[0] ? NREQ'(1) : {req[NREQ-1:1], 1'b0};
`else
    assign cand = req;
`endif

    // First candidate found walking upward from ptr+1 wins; the last owner is checked last.
    always_comb begin
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!any && cand[j]) begin
                any = 1'b1;
                idx = IW'(j);
            end
        end
        gnt = any ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/main_mem_arbiter.sv
// main_mem_arbiter: one-at-a-time MainMemory access arbiter with one-cycle strobes; option macro MAIN_MEM_ARB_PRIO_EN.
module main_mem_arbiter #(
    parameter int NREQ      = 3,
    parameter int DW        = main_mem_arb_pkg::DW,
    parameter int AW        = main_mem_arb_pkg::AW,
    parameter int MEM_DEPTH = 9
) (
    input logic               Clk,
    input logic               nReset,
    main_mem_arbiter_if.slave bus
);
    import main_mem_arb_pkg::*;

    localparam int IW = $clog2(NREQ);

    arb_state_t      state, state_n;
    logic [IW-1:0]   ptr, owner, pick_idx;
    logic [NREQ-1:0] owner_oh, pick_oh;
    logic            pick_any, wr_q;
    logic [AW-1:0]   addr_q, pick_addr;
    logic [DW-1:0]   wdata_q, rdata_q;

    main_mem_rr_picker #(.NREQ(NREQ)) u_picker (
        .req (bus.req),
        .ptr (ptr),
        .gnt (pick_oh),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign pick_addr = bus.req_addr[pick_idx*AW +: AW];

    // State register
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_n;
    end

    // Next state: bad addresses skip the memory and report straight away
    always_comb begin
        state_n = (state == IDLE)  ? (!pick_any ? IDLE : addr_valid(pick_addr, MEM_DEPTH) ? ISSUE : ERR) :
                  (state == ISSUE) ? (wr_q ? DONE : WAIT) :
                  (state == WAIT)  ? DONE : IDLE;
    end

    // Transaction capture in IDLE, read data capture in WAIT, fairness pointer update on completion
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            ptr      <= IW'(NREQ - 1);
            owner    <= '0;
            owner_oh <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (state == IDLE && pick_any) begin
                owner    <= pick_idx;
                owner_oh <= pick_oh;
                wr_q     <= bus.wr[pick_idx];
                addr_q   <= pick_addr;
                wdata_q  <= bus.req_wdata[pick_idx*DW +: DW];
            end
            if (state == WAIT) rdata_q <= bus.MemDataOut;
            if (state == DONE || state == ERR) ptr <= owner;
        end
    end

    // State-decoded outputs; strobes can only fall in ISSUE and only one by construction
    always_comb begin
        bus.gnt    = (state == ISSUE) ? owner_oh : '0;
        bus.done   = (state == DONE || state == ERR) ? owner_oh : '0;
        bus.err    = (state == ERR);
        bus.busy   = (state != IDLE);
        bus.nRead  = !(state == ISSUE && !wr_q);
        bus.nWrite = !(state == ISSUE && wr_q);
    end

    assign bus.address    = addr_q;
    assign bus.ExeDataOut = wdata_q;
    assign bus.rdata      = rdata_q;

endmodule

// File: tb/tb_main_mem_arbiter.sv
// tb_main_mem_arbiter: directed self-checking bench with a MainMemory model.
module tb_main_mem_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 256;
    localparam int AW   = 16;

    localparam logic [DW-1:0] W0 = {16'h0004, 16'h0004, 208'h0, 16'h0005};
    localparam logic [DW-1:0] W1 = {16'h0017, 16'h002d, 208'h0, 16'h0002};
    localparam logic [DW-1:0] W8 = {16{16'h0008}};

    logic Clk = 1'b0;
    logic nReset = 1'b0;
    int compared = 0;
    int mismatched = 0;

    always #5 Clk = ~Clk;

    main_mem_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bi ();

    main_mem_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .MEM_DEPTH(9)) dut (
        .Clk    (Clk),
        .nReset (nReset),
        .bus    (bi)
    );

    logic [DW-1:0] mem [0:8];
    logic mem_init = 1'b0;

    function automatic logic [DW-1:0] init_word(input int i);
        return (i == 0) ? W0 : (i == 1) ? W1 : {16{16'(i)}};
    endfunction

    // MainMemory model: read data appears the cycle after the nRead cycle
    always @(posedge Clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 9; i++) mem[i] <= init_word(i);
            mem_init <= 1'b1;
        end else begin
            if (!bi.nRead && bi.address[11:0] < 12'd9) bi.MemDataOut <= mem[bi.address[3:0]];
            if (!bi.nWrite && bi.address[11:0] < 12'd9) mem[bi.address[3:0]] <= bi.ExeDataOut;
        end
    end

    // Protocol monitor every cycle out of reset
    always @(negedge Clk) begin
        if (nReset) begin
            compared++;
            if ((!bi.nRead && !bi.nWrite) || !$onehot0(bi.gnt) || !$onehot0(bi.done) ||
                ((!bi.nRead || !bi.nWrite) && bi.gnt == '0)) begin
                mismatched++;
                $display("FAIL protocol @%0t: nRead=%b nWrite=%b gnt=%b done=%b, want exclusive strobes with one-hot gnt",
                         $time, bi.nRead, bi.nWrite, bi.gnt, bi.done);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_txn(input int r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int lat, output logic [DW-1:0] rd, output logic e,
                          output int nrl, output int nwl, output logic [AW-1:0] sa,
                          output logic [NREQ-1:0] gs, output logic extra);
        lat = -1; rd = '0; e = 1'b0; nrl = 0; nwl = 0; sa = '0; gs = '0; extra = 1'b0;
        bi.req[r] = 1'b1;
        bi.wr[r] = w;
        bi.req_addr[r*AW +: AW] = a;
        bi.req_wdata[r*DW +: DW] = d;
        for (int c = 1; c <= 20; c++) begin
            @(negedge Clk);
            if (!bi.nRead) begin nrl++; sa = bi.address; end
            if (!bi.nWrite) begin nwl++; sa = bi.address; end
            gs |= bi.gnt;
            if (bi.done[r]) begin
                lat = c; rd = bi.rdata; e = bi.err;
                break;
            end
        end
        bi.req[r] = 1'b0;
        bi.wr[r] = 1'b0;
        @(negedge Clk);
        extra = |bi.done;
    endtask

    task automatic test_reset();
        bi.req = '0; bi.wr = '0; bi.req_addr = '0; bi.req_wdata = '0;
        nReset = 1'b0;
        repeat (3) @(negedge Clk);
        bi.req[1] = 1'b1;
        bi.req_addr[AW +: AW] = 16'h0003;
        @(negedge Clk);
        compared++; if (bi.nRead !== 1'b1) begin mismatched++; $display("FAIL reset_nRead: got %b want 1", bi.nRead); end
        compared++; if (bi.nWrite !== 1'b1) begin mismatched++; $display("FAIL reset_nWrite: got %b want 1", bi.nWrite); end
        compared++; if (bi.gnt !== 3'b000) begin mismatched++; $display("FAIL reset_gnt: got %b want 000", bi.gnt); end
        compared++; if (bi.done !== 3'b000) begin mismatched++; $display("FAIL reset_done: got %b want 000", bi.done); end
        compared++; if (bi.err !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b want 0", bi.err); end
        compared++; if (bi.busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", bi.busy); end
        compared++; if (bi.rdata !== '0) begin mismatched++; $display("FAIL reset_rdata: got %h want 0", bi.rdata); end
        compared++; if (bi.address !== '0) begin mismatched++; $display("FAIL reset_address: got %h want 0", bi.address); end
        compared++; if (bi.ExeDataOut !== '0) begin mismatched++; $display("FAIL reset_exedata: got %h want 0", bi.ExeDataOut); end
        bi.req = '0;
        bi.req_addr = '0;
        nReset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_contention();
        int o;
        int want;
        logic found;
        bi.wr = '0;
        bi.req_addr = {16'h0004, 16'h0003, 16'h0002};
        bi.req = 3'b111;
        for (int i = 0; i < 6; i++) begin
`ifdef MAIN_MEM_ARB_PRIO_EN
            want = 0;
`else
            want = i % 3;
`endif
            found = 1'b0;
            o = -1;
            for (int c = 0; c < 10 && !found; c++) begin
                @(negedge Clk);
                if (|bi.done) begin
                    found = 1'b1;
                    for (int k = 0; k < NREQ; k++) if (bi.done[k]) o = k;
                end
            end
            compared++;
            if (o != want) begin mismatched++; $display("FAIL contention_order[%0d]: got owner %0d want %0d", i, o, want); end
        end
        bi.req = '0;
        repeat (2) @(negedge Clk);
        compared++; if (bi.busy !== 1'b0) begin mismatched++; $display("FAIL contention_idle: busy got %b want 0", bi.busy); end
    endtask

    task automatic test_single_read();
        int lat, nrl, nwl;
        logic [DW-1:0] rd;
        logic e, extra;
        logic [AW-1:0] sa;
        logic [NREQ-1:0] gs;
        do_txn(0, 1'b0, 16'h0001, '0, lat, rd, e, nrl, nwl, sa, gs, extra);
        compared++; if (lat != 3) begin mismatched++; $display("FAIL read_latency: got %0d want 3", lat); end
        compared++; if (rd !== W1) begin mismatched++; $display("FAIL read_rdata: got %h want %h", rd, W1); end
        compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL read_err: got %b want 0", e); end
        compared++; if (nrl != 1) begin mismatched++; $display("FAIL read_nRead_cycles: got %0d want 1", nrl); end
        compared++; if (nwl != 0) begin mismatched++; $display("FAIL read_nWrite_cycles: got %0d want 0", nwl); end
        compared++; if (sa !== 16'h0001) begin mismatched++; $display("FAIL read_address: got %h want 0001", sa); end
        compared++; if (gs !== 3'b001) begin mismatched++; $display("FAIL read_gnt: got %b want 001", gs); end
        compared++; if (extra !== 1'b0) begin mismatched++; $display("FAIL read_done_once: extra done got %b want 0", extra); end
    endtask

    task automatic test_write_read();
        int lat, nrl, nwl;
        logic [DW-1:0] rd;
        logic e, extra;
        logic [AW-1:0] sa;
        logic [NREQ-1:0] gs;
        do_txn(1, 1'b1, 16'h0005, 256'hA5, lat, rd, e, nrl, nwl, sa, gs, extra);
        compared++; if (lat != 2) begin mismatched++; $display("FAIL write_latency: got %0d want 2", lat); end
        compared++; if (nwl != 1) begin mismatched++; $display("FAIL write_nWrite_cycles: got %0d want 1", nwl); end
        compared++; if (nrl != 0) begin mismatched++; $display("FAIL write_nRead_cycles: got %0d want 0", nrl); end
        compared++; if (sa !== 16'h0005) begin mismatched++; $display("FAIL write_address: got %h want 0005", sa); end
        compared++; if (gs !== 3'b010) begin mismatched++; $display("FAIL write_gnt: got %b want 010", gs); end
        compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL write_err: got %b want 0", e); end
        do_txn(0, 1'b0, 16'h0005, '0, lat, rd, e, nrl, nwl, sa, gs, extra);
        compared++; if (rd !== 256'hA5) begin mismatched++; $display("FAIL readback_rdata: got %h want a5", rd); end
        compared++; if (lat != 3) begin mismatched++; $display("FAIL readback_latency: got %0d want 3", lat); end
        do_txn(2, 1'b0, 16'h0008, '0, lat, rd, e, nrl, nwl, sa, gs, extra);
        compared++; if (rd !== W8) begin mismatched++; $display("FAIL last_word_rdata: got %h want %h", rd, W8); end
        compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL last_word_err: got %b want 0", e); end
    endtask

    task automatic test_bad_addr();
        int lat, nrl, nwl;
        logic [DW-1:0] rd;
        logic e, extra;
        logic [AW-1:0] sa;
        logic [NREQ-1:0] gs;
        logic [AW-1:0] bad [3];
        logic wbad [3];
        bad = '{16'h1002, 16'h0009, 16'hF000};
        wbad = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            do_txn(2, wbad[i], bad[i], 256'h77, lat, rd, e, nrl, nwl, sa, gs, extra);
            compared++; if (lat != 1) begin mismatched++; $display("FAIL bad_latency[%h]: got %0d want 1", bad[i], lat); end
            compared++; if (e !== 1'b1) begin mismatched++; $display("FAIL bad_err[%h]: got %b want 1", bad[i], e); end
            compared++; if (nrl + nwl != 0) begin mismatched++; $display("FAIL bad_strobes[%h]: got %0d low cycles want 0", bad[i], nrl + nwl); end
            compared++; if (gs !== 3'b000) begin mismatched++; $display("FAIL bad_gnt[%h]: got %b want 000", bad[i], gs); end
            compared++; if (rd !== W8) begin mismatched++; $display("FAIL bad_rdata_hold[%h]: got %h want %h", bad[i], rd, W8); end
        end
    endtask

    task automatic test_reset_midop();
        int lat, nrl, nwl;
        logic [DW-1:0] rd;
        logic e, extra;
        logic [AW-1:0] sa;
        logic [NREQ-1:0] gs;
        bi.req[0] = 1'b1;
        bi.wr[0] = 1'b0;
        bi.req_addr[0 +: AW] = 16'h0001;
        repeat (2) @(negedge Clk);
        compared++; if (bi.busy !== 1'b1 || bi.nRead !== 1'b1) begin mismatched++; $display("FAIL midop_wait: busy=%b nRead=%b want 1 1", bi.busy, bi.nRead); end
        nReset = 1'b0;
        #1;
        compared++; if (bi.nRead !== 1'b1 || bi.nWrite !== 1'b1) begin mismatched++; $display("FAIL midop_strobes: got %b%b want 11", bi.nRead, bi.nWrite); end
        compared++; if (bi.busy !== 1'b0) begin mismatched++; $display("FAIL midop_busy: got %b want 0", bi.busy); end
        compared++; if (bi.rdata !== '0) begin mismatched++; $display("FAIL midop_rdata: got %h want 0", bi.rdata); end
        bi.req = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            compared++; if (bi.done !== 3'b000) begin mismatched++; $display("FAIL midop_no_done: got %b want 000", bi.done); end
        end
        nReset = 1'b1;
        @(negedge Clk);
        do_txn(2, 1'b0, 16'h0000, '0, lat, rd, e, nrl, nwl, sa, gs, extra);
        compared++; if (rd !== W0) begin mismatched++; $display("FAIL post_reset_rdata: got %h want %h", rd, W0); end
        compared++; if (lat != 3) begin mismatched++; $display("FAIL post_reset_latency: got %0d want 3", lat); end
        compared++; if (gs !== 3'b100) begin mismatched++; $display("FAIL post_reset_gnt: got %b want 100", gs); end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_read();
        test_write_read();
        test_bad_addr();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
